// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson counter family: direction encodings,
// per-edge operation selector and a constant-evaluable ceiling-log2 helper.
package johnson_pkg;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // What the flops do on the next edge, highest priority first.
    typedef enum logic [1:0] {
        OP_SCAN,
        OP_CLEAR,
        OP_COUNT,
        OP_HOLD
    } op_e;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/johnson_phase_dec.sv
// Combinational decoder: classifies a ring value as a legal Johnson code and
// converts it to its position 0..2*WIDTH-1 in the up-count sequence.
module johnson_phase_dec
    import johnson_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PHASE_W = clog2(2 * WIDTH)
) (
    input  logic [0:WIDTH-1]   code_i,
    output logic [PHASE_W-1:0] phase_o,
    output logic               legal_o
);

    int ones;
    int edges;
    int phase_int;

    // NOTE: every variable gets a value before any branch, so no latch is inferred.
    always_comb begin
        ones      = 0;
        edges     = 0;
        phase_int = 0;
        for (int i = 0; i < WIDTH; i++) begin
            ones += int'(code_i[i]);
        end
        // A legal code is one run of ones and one run of zeros: at most one boundary.
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (code_i[i] != code_i[i+1]) begin
                edges++;
            end
        end
        legal_o = (edges <= 1);
        if (legal_o) begin
            if (code_i[0]) begin
                phase_int = ones;
            end else if (ones != 0) begin
                phase_int = 2 * WIDTH - ones;
            end
        end
        phase_o = PHASE_W'(phase_int);
    end

endmodule

// File: rtl/johnson_count_param.sv
// Parametrised twisted-ring counter with up/down, clear, terminal-count pulse,
// sticky illegal-state flag and a scan chain through every flop.
module johnson_count_param
    import johnson_pkg::*;
#(
    parameter int  WIDTH        = 8,
    parameter bit  SELF_CORRECT = 1'b1,
    localparam int PHASE_W      = clog2(2 * WIDTH)
) (
    input  logic               clk,
    input  logic               r_n,
    input  logic               SE,
    input  logic               SCANINPORT,
    output logic               SCANOUTPORT,
    input  logic               en,
    input  logic               dir,
    input  logic               clr,
    output logic [0:WIDTH-1]   out,
    output logic [PHASE_W-1:0] phase,
    output logic               legal,
    output logic               tc,
    output logic               err
);

    logic [0:WIDTH-1] out_q, out_d;
    logic             tc_q, tc_d;
    logic             err_q, err_d;
    logic [0:WIDTH-1] stepped;
    op_e              op;

    johnson_phase_dec #(
        .WIDTH  (WIDTH),
        .PHASE_W(PHASE_W)
    ) u_phase_dec (
        .code_i (out_q),
        .phase_o(phase),
        .legal_o(legal)
    );

    always_comb begin
        if (SE) begin
            op = OP_SCAN;
        end else if (clr) begin
            op = OP_CLEAR;
        end else if (en) begin
            op = OP_COUNT;
        end else begin
            op = OP_HOLD;
        end

        // Up feeds the inverted last stage into bit 0; down runs the ring backwards.
        if (dir == DIR_DN) begin
            stepped = {out_q[1:WIDTH-1], ~out_q[0]};
        end else begin
            stepped = {~out_q[WIDTH-1], out_q[0:WIDTH-2]};
        end

        out_d = out_q;
        tc_d  = 1'b0;
        err_d = err_q;
        case (op)
            OP_SCAN: begin
                out_d = {SCANINPORT, out_q[0:WIDTH-2]};
                tc_d  = out_q[WIDTH-1];
                err_d = tc_q;
            end
            OP_CLEAR: begin
                out_d = '0;
                err_d = 1'b0;
            end
            OP_COUNT: begin
                if (legal) begin
                    out_d = stepped;
                    tc_d  = (stepped == '0);
                end else begin
                    err_d = 1'b1;
                    out_d = SELF_CORRECT ? '0 : stepped;
                end
            end
            default: begin
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            out_q <= '0;
            tc_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            out_q <= out_d;
            tc_q  <= tc_d;
            err_q <= err_d;
        end
    end

    assign out         = out_q;
    assign tc          = tc_q;
    assign err         = err_q;
    assign SCANOUTPORT = err_q;

endmodule
